magia_eu_obi_arbiter: RTL and testbench

MAGIA_EU_OBI_ARBITER -- requirements
Module: magia_eu_obi_arbiter

---
 rtl/magia_eu_obi_arbiter.sv | 149 ++++++++++++++
 tb/tb_magia_eu_obi_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/magia_eu_obi_arbiter.sv
// Round-robin OBI arbiter in front of the event-unit slave port.
// Out-of-window accesses are answered locally with an error response.
module magia_eu_obi_arbiter #(
  parameter int unsigned NB_REQ    = 2,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MAX_OUTST = 2,
  parameter logic [ADDR_W-1:0] EU_ADDR_START = ADDR_W'(32'h0001_0000),
  parameter logic [ADDR_W-1:0] EU_ADDR_END   = ADDR_W'(32'h0001_00FF)
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [NB_REQ-1:0]                m_req_i,
  input  logic [NB_REQ-1:0][ADDR_W-1:0]    m_addr_i,
  input  logic [NB_REQ-1:0]                m_we_i,
  input  logic [NB_REQ-1:0][DATA_W/8-1:0]  m_be_i,
  input  logic [NB_REQ-1:0][DATA_W-1:0]    m_wdata_i,
  output logic [NB_REQ-1:0]                m_gnt_o,
  output logic [NB_REQ-1:0]                m_rvalid_o,
  output logic [NB_REQ-1:0]                m_err_o,
  output logic [NB_REQ-1:0][DATA_W-1:0]    m_rdata_o,
  output logic                             s_req_o,
  output logic [ADDR_W-1:0]                s_addr_o,
  output logic                             s_we_o,
  output logic [DATA_W/8-1:0]              s_be_o,
  output logic [DATA_W-1:0]                s_wdata_o,
  input  logic                             s_gnt_i,
  input  logic                             s_rvalid_i,
  input  logic [DATA_W-1:0]                s_rdata_i
);

  localparam int unsigned IDX_W = (NB_REQ > 1) ? $clog2(NB_REQ) : 1;
  localparam int unsigned PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_OUTST + 1);
  localparam logic [DATA_W-1:0] ERR_DATA = DATA_W'(32'hBADACCE5);

  typedef enum logic {IDLE, ERR_RSP} state_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    rr_q, lock_idx_q, err_idx_q, win_idx, head_idx;
  logic                lock_q, win_valid, win_in_range, fwd, local_gnt;
  logic                blocked, push, pop, proto_err_q;
  logic [NB_REQ-1:0]   in_range, elig;
  logic [IDX_W-1:0]    fifo_q [MAX_OUTST];
  logic [PTR_W-1:0]    wptr_q, rptr_q;
  logic [CNT_W-1:0]    cnt_q;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTST - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // A full FIFO still takes a push in the cycle it pops.
  assign blocked  = (cnt_q == CNT_W'(MAX_OUTST)) && !s_rvalid_i;
  assign pop      = s_rvalid_i && (cnt_q != '0) && !rst_i;
  assign head_idx = fifo_q[rptr_q];

  always_comb begin
    in_range = '0;
    elig     = '0;
    for (int i = 0; i < NB_REQ; i++) begin
      in_range[i] = (m_addr_i[i] >= EU_ADDR_START) && (m_addr_i[i] <= EU_ADDR_END);
      elig[i]     = m_req_i[i] && !blocked &&
                    (in_range[i] || ((cnt_q == '0) && (state_q == IDLE)));
    end
  end

  // Scan from lowest to highest priority so the last hit is the winner.
  always_comb begin
    int unsigned cand;
    cand      = 0;
    win_valid = 1'b0;
    win_idx   = rr_q;
    if (lock_q) begin
      win_idx   = lock_idx_q;
      win_valid = elig[lock_idx_q];
    end else begin
      for (int i = NB_REQ - 1; i >= 0; i--) begin
        cand = (int'(rr_q) + i) % NB_REQ;
        if (elig[cand]) begin
          win_valid = 1'b1;
          win_idx   = IDX_W'(cand);
        end
      end
    end
  end

  assign win_in_range = in_range[win_idx];
  assign fwd          = win_valid && win_in_range && !rst_i;
  assign local_gnt    = win_valid && !win_in_range && !rst_i;
  assign push         = fwd && s_gnt_i;

  always_comb begin
    s_req_o    = fwd;
    s_addr_o   = m_addr_i[win_idx] - EU_ADDR_START;
    s_we_o     = m_we_i[win_idx];
    s_be_o     = m_be_i[win_idx];
    s_wdata_o  = m_wdata_i[win_idx];
    m_gnt_o    = '0;
    m_rvalid_o = '0;
    m_err_o    = '0;
    m_rdata_o  = '0;
    if (fwd)       m_gnt_o[win_idx] = s_gnt_i;
    if (local_gnt) m_gnt_o[win_idx] = 1'b1;
    if (pop) begin
      m_rvalid_o[head_idx] = 1'b1;
      m_rdata_o[head_idx]  = s_rdata_i;
    end
    if ((state_q == ERR_RSP) && !rst_i) begin
      m_rvalid_o[err_idx_q] = 1'b1;
      m_err_o[err_idx_q]    = 1'b1;
      m_rdata_o[err_idx_q]  = ERR_DATA;
    end
  end

  always_comb begin
    state_d = IDLE;
    if ((state_q == IDLE) && local_gnt) state_d = ERR_RSP;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      rr_q        <= '0;
      lock_q      <= 1'b0;
      lock_idx_q  <= '0;
      err_idx_q   <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      cnt_q       <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lock_q  <= fwd && !s_gnt_i;
      if (fwd && !s_gnt_i) lock_idx_q <= win_idx;
      if (push || local_gnt)
        rr_q <= (win_idx == IDX_W'(NB_REQ - 1)) ? '0 : win_idx + IDX_W'(1);
      if (local_gnt) err_idx_q <= win_idx;
      if (push) begin
        fifo_q[wptr_q] <= win_idx;
        wptr_q         <= ptr_inc(wptr_q);
      end
      if (pop) rptr_q <= ptr_inc(rptr_q);
      if (push && !pop)      cnt_q <= cnt_q + CNT_W'(1);
      else if (pop && !push) cnt_q <= cnt_q - CNT_W'(1);
      if (s_rvalid_i && (cnt_q == '0)) proto_err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_magia_eu_obi_arbiter.sv
// Directed self-checking bench for magia_eu_obi_arbiter (2 requesters, depth 2).
module tb_magia_eu_obi_arbiter;

  localparam logic [31:0] START = 32'h0001_0000;
  localparam logic [31:0] ENDA  = 32'h0001_00FF;
  localparam logic [31:0] D0    = 32'hD000_0000;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic [1:0]       m_req_i;
  logic [1:0][31:0] m_addr_i;
  logic [1:0]       m_we_i;
  logic [1:0][3:0]  m_be_i;
  logic [1:0][31:0] m_wdata_i;
  logic [1:0]       m_gnt_o, m_rvalid_o, m_err_o;
  logic [1:0][31:0] m_rdata_o;
  logic             s_req_o, s_we_o, s_gnt_i, s_rvalid_i;
  logic [31:0]      s_addr_o, s_wdata_o, s_rdata_i;
  logic [3:0]       s_be_o;
  int               checks = 0;
  int               failures = 0;

  magia_eu_obi_arbiter #(
    .NB_REQ(2), .ADDR_W(32), .DATA_W(32), .MAX_OUTST(2),
    .EU_ADDR_START(START), .EU_ADDR_END(ENDA)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m_req_i(m_req_i), .m_addr_i(m_addr_i), .m_we_i(m_we_i), .m_be_i(m_be_i),
    .m_wdata_i(m_wdata_i), .m_gnt_o(m_gnt_o), .m_rvalid_o(m_rvalid_o),
    .m_err_o(m_err_o), .m_rdata_o(m_rdata_o),
    .s_req_o(s_req_o), .s_addr_o(s_addr_o), .s_we_o(s_we_o), .s_be_o(s_be_o),
    .s_wdata_o(s_wdata_o), .s_gnt_i(s_gnt_i), .s_rvalid_i(s_rvalid_i),
    .s_rdata_i(s_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs;
    m_req_i = '0; m_addr_i = '0; m_we_i = '0; m_be_i = '0; m_wdata_i = '0;
    s_gnt_i = 1'b0; s_rvalid_i = 1'b0; s_rdata_i = '0;
  endtask

  task automatic test_reset;
    rst_i = 1'b1;
    idle_inputs();
    tick();
    m_req_i = 2'b11; m_addr_i[0] = START; m_addr_i[1] = START; s_gnt_i = 1'b1; s_rvalid_i = 1'b1;
    #1;
    checks++; if (s_req_o !== 1'b0) begin failures++; $display("FAIL rst_sreq got %b exp 0", s_req_o); end
    checks++; if (m_gnt_o !== 2'b00) begin failures++; $display("FAIL rst_gnt got %b exp 00", m_gnt_o); end
    checks++; if (m_rvalid_o !== 2'b00) begin failures++; $display("FAIL rst_rvalid got %b exp 00", m_rvalid_o); end
    tick();
    checks++; if (dut.proto_err_q !== 1'b0) begin failures++; $display("FAIL rst_proto got %b exp 0", dut.proto_err_q); end
    rst_i = 1'b0;
    idle_inputs();
  endtask

  // Both requesters stream reads; grants alternate and responses follow in order.
  task automatic test_round_robin;
    logic [1:0] exp_gnt, exp_rv;
    int         r;
    m_req_i = 2'b11; m_addr_i[0] = START; m_addr_i[1] = START + 32'h4; s_gnt_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      s_rvalid_i = (k != 0);
      s_rdata_i  = D0 + 32'(k);
      #1;
      exp_gnt = (k % 2 == 0) ? 2'b01 : 2'b10;
      exp_rv  = (k == 0) ? 2'b00 : ((k % 2 == 1) ? 2'b01 : 2'b10);
      r       = (k % 2 == 1) ? 0 : 1;
      checks++; if (m_gnt_o !== exp_gnt) begin failures++; $display("FAIL rr_gnt[%0d] got %b exp %b", k, m_gnt_o, exp_gnt); end
      checks++; if (m_rvalid_o !== exp_rv) begin failures++; $display("FAIL rr_rvalid[%0d] got %b exp %b", k, m_rvalid_o, exp_rv); end
      if (k != 0) begin
        checks++; if (m_rdata_o[r] !== D0 + 32'(k)) begin failures++; $display("FAIL rr_rdata[%0d] got %h exp %h", k, m_rdata_o[r], D0 + 32'(k)); end
      end
      tick();
    end
    m_req_i = 2'b00; s_rvalid_i = 1'b1; s_rdata_i = D0 + 32'd4;
    #1;
    checks++; if (m_rvalid_o !== 2'b10 || m_rdata_o[1] !== D0 + 32'd4) begin failures++; $display("FAIL rr_last got %b/%h exp 10/%h", m_rvalid_o, m_rdata_o[1], D0 + 32'd4); end
    tick();
    idle_inputs();
  endtask

  // Requester 0 waits on a stalled slave; requester 1 (higher priority) must not steal the slot.
  task automatic test_hold;
    m_req_i = 2'b01; m_addr_i[0] = START + 32'h20; m_we_i[0] = 1'b1; s_gnt_i = 1'b1;
    #1;
    checks++; if (m_gnt_o !== 2'b01) begin failures++; $display("FAIL hold_pre got %b exp 01", m_gnt_o); end
    tick();
    m_req_i = 2'b00; s_gnt_i = 1'b0; s_rvalid_i = 1'b1;
    #1;
    checks++; if (m_rvalid_o !== 2'b01) begin failures++; $display("FAIL hold_prersp got %b exp 01", m_rvalid_o); end
    tick();
    s_rvalid_i = 1'b0; m_addr_i[1] = START + 32'h30; m_we_i[1] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      m_req_i = (c == 0) ? 2'b01 : 2'b11;
      #1;
      checks++; if (s_req_o !== 1'b1 || s_addr_o !== 32'h20 || s_we_o !== 1'b1) begin failures++; $display("FAIL hold_stable[%0d] got %b/%h/%b exp 1/00000020/1", c, s_req_o, s_addr_o, s_we_o); end
      checks++; if (m_gnt_o !== 2'b00) begin failures++; $display("FAIL hold_nognt[%0d] got %b exp 00", c, m_gnt_o); end
      tick();
    end
    s_gnt_i = 1'b1;
    #1;
    checks++; if (m_gnt_o !== 2'b01 || s_addr_o !== 32'h20) begin failures++; $display("FAIL hold_gnt0 got %b/%h exp 01/00000020", m_gnt_o, s_addr_o); end
    tick();
    m_req_i = 2'b10;
    #1;
    checks++; if (m_gnt_o !== 2'b10 || s_addr_o !== 32'h30) begin failures++; $display("FAIL hold_gnt1 got %b/%h exp 10/00000030", m_gnt_o, s_addr_o); end
    tick();
    m_req_i = 2'b00; s_gnt_i = 1'b0; s_rvalid_i = 1'b1;
    #1;
    checks++; if (m_rvalid_o !== 2'b01) begin failures++; $display("FAIL hold_rsp0 got %b exp 01", m_rvalid_o); end
    tick();
    checks++; if (m_rvalid_o !== 2'b10) begin failures++; $display("FAIL hold_rsp1 got %b exp 10", m_rvalid_o); end
    tick();
    idle_inputs();
  endtask

  task automatic test_outstanding;
    m_req_i = 2'b01; m_addr_i[0] = START + 32'h40; s_gnt_i = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++; if (m_gnt_o !== ((c < 2) ? 2'b01 : 2'b00)) begin failures++; $display("FAIL outst_gnt[%0d] got %b exp %b", c, m_gnt_o, (c < 2) ? 2'b01 : 2'b00); end
      if (c >= 2) begin
        checks++; if (s_req_o !== 1'b0) begin failures++; $display("FAIL outst_sreq[%0d] got %b exp 0", c, s_req_o); end
      end
      tick();
    end
    s_rvalid_i = 1'b1;
    #1;
    checks++; if (m_gnt_o !== 2'b01 || m_rvalid_o !== 2'b01) begin failures++; $display("FAIL outst_swap got %b/%b exp 01/01", m_gnt_o, m_rvalid_o); end
    tick();
    checks++; if (dut.cnt_q !== 2'd2) begin failures++; $display("FAIL outst_occ got %0d exp 2", dut.cnt_q); end
    m_req_i = 2'b00;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++; if (m_rvalid_o !== 2'b01) begin failures++; $display("FAIL outst_drain[%0d] got %b exp 01", c, m_rvalid_o); end
      tick();
    end
    idle_inputs();
    #1;
    checks++; if (dut.cnt_q !== 2'd0) begin failures++; $display("FAIL outst_empty got %0d exp 0", dut.cnt_q); end
  endtask

  task automatic test_out_of_range;
    m_req_i = 2'b01; m_addr_i[0] = START + 32'h50; s_gnt_i = 1'b1;
    #1;
    checks++; if (m_gnt_o !== 2'b01) begin failures++; $display("FAIL oor_pre got %b exp 01", m_gnt_o); end
    tick();
    m_req_i = 2'b10; m_addr_i[1] = ENDA + 32'h4;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++; if (m_gnt_o !== 2'b00 || s_req_o !== 1'b0) begin failures++; $display("FAIL oor_wait[%0d] got %b/%b exp 00/0", c, m_gnt_o, s_req_o); end
      tick();
    end
    s_rvalid_i = 1'b1;
    #1;
    checks++; if (m_rvalid_o !== 2'b01 || m_gnt_o !== 2'b00) begin failures++; $display("FAIL oor_rsp0 got %b/%b exp 01/00", m_rvalid_o, m_gnt_o); end
    tick();
    s_rvalid_i = 1'b0;
    #1;
    checks++; if (m_gnt_o !== 2'b10 || s_req_o !== 1'b0) begin failures++; $display("FAIL oor_gnt got %b/%b exp 10/0", m_gnt_o, s_req_o); end
    tick();
    m_req_i = 2'b00;
    #1;
    checks++; if (m_rvalid_o !== 2'b10 || m_err_o !== 2'b10) begin failures++; $display("FAIL oor_err got %b/%b exp 10/10", m_rvalid_o, m_err_o); end
    checks++; if (m_rdata_o[1] !== 32'hBADACCE5 || s_req_o !== 1'b0) begin failures++; $display("FAIL oor_data got %h/%b exp badacce5/0", m_rdata_o[1], s_req_o); end
    tick();
    checks++; if (m_rvalid_o !== 2'b00 || m_err_o !== 2'b00) begin failures++; $display("FAIL oor_done got %b/%b exp 00/00", m_rvalid_o, m_err_o); end
    idle_inputs();
  endtask

  task automatic test_reset_outstanding;
    m_req_i = 2'b01; m_addr_i[0] = START; m_addr_i[1] = START + 32'h4; s_gnt_i = 1'b1;
    #1;
    checks++; if (m_gnt_o !== 2'b01) begin failures++; $display("FAIL rsto_gnt0 got %b exp 01", m_gnt_o); end
    tick();
    m_req_i = 2'b10;
    #1;
    checks++; if (m_gnt_o !== 2'b10) begin failures++; $display("FAIL rsto_gnt1 got %b exp 10", m_gnt_o); end
    tick();
    rst_i = 1'b1; m_req_i = 2'b11; s_rvalid_i = 1'b1;
    #1;
    checks++; if ({s_req_o, m_gnt_o, m_rvalid_o, m_err_o} !== 7'b0) begin failures++; $display("FAIL rsto_quiet got %b exp 0000000", {s_req_o, m_gnt_o, m_rvalid_o, m_err_o}); end
    tick();
    rst_i = 1'b0; m_req_i = 2'b00; s_gnt_i = 1'b0; s_rvalid_i = 1'b1;
    #1;
    checks++; if (m_rvalid_o !== 2'b00) begin failures++; $display("FAIL rsto_stray got %b exp 00", m_rvalid_o); end
    tick();
    s_rvalid_i = 1'b0;
    #1;
    checks++; if (dut.proto_err_q !== 1'b1 || dut.cnt_q !== 2'd0) begin failures++; $display("FAIL rsto_proto got %b/%0d exp 1/0", dut.proto_err_q, dut.cnt_q); end
    idle_inputs();
  endtask

  task automatic test_addr_offset;
    m_req_i = 2'b01; m_addr_i[0] = START + 32'h10; m_we_i[0] = 1'b1; m_be_i[0] = 4'b0101;
    m_wdata_i[0] = 32'hCAFEF00D; s_gnt_i = 1'b1;
    #1;
    checks++; if (s_addr_o !== 32'h10 || s_we_o !== 1'b1) begin failures++; $display("FAIL ofs_addr got %h/%b exp 00000010/1", s_addr_o, s_we_o); end
    checks++; if (s_be_o !== 4'b0101 || s_wdata_o !== 32'hCAFEF00D) begin failures++; $display("FAIL ofs_data got %b/%h exp 0101/cafef00d", s_be_o, s_wdata_o); end
    checks++; if (m_gnt_o !== 2'b01) begin failures++; $display("FAIL ofs_gnt0 got %b exp 01", m_gnt_o); end
    tick();
    m_req_i = 2'b10; m_addr_i[1] = ENDA; m_we_i[1] = 1'b1; m_be_i[1] = 4'b1000; m_wdata_i[1] = 32'h1234_5678;
    #1;
    checks++; if (s_req_o !== 1'b1 || s_addr_o !== 32'hFF || s_be_o !== 4'b1000) begin failures++; $display("FAIL ofs_end got %b/%h/%b exp 1/000000ff/1000", s_req_o, s_addr_o, s_be_o); end
    checks++; if (m_gnt_o !== 2'b10 || s_wdata_o !== 32'h1234_5678) begin failures++; $display("FAIL ofs_gnt1 got %b/%h exp 10/12345678", m_gnt_o, s_wdata_o); end
    tick();
    m_req_i = 2'b00; s_gnt_i = 1'b0; s_rvalid_i = 1'b1;
    #1;
    checks++; if (m_rvalid_o !== 2'b01) begin failures++; $display("FAIL ofs_rsp0 got %b exp 01", m_rvalid_o); end
    tick();
    checks++; if (m_rvalid_o !== 2'b10) begin failures++; $display("FAIL ofs_rsp1 got %b exp 10", m_rvalid_o); end
    tick();
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_hold();
    test_outstanding();
    test_out_of_range();
    test_reset_outstanding();
    test_addr_offset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
